lanzones: RTL and testbench

//  Multicycle RV32I processor core with one shared instruction/data memory port.

---
 rtl/lanzones_pkg.sv | 77 +++++++
 rtl/lanzones_alu.sv | 53 +++++
 rtl/lanzones.sv | 204 ++++++++++++++++++++
 tb/tb_lanzones.sv | 408 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lanzones_pkg.sv
// lanzones_pkg: shared constants and types for the lanzones RV32I core.
//   - RV32I opcode and funct3 codes
//   - FSM state enum, ALU op enum, ALU op decode helper
//   - Build option LANZONES_ILLEGAL_HALT_EN: when defined, an unknown opcode halts
//     the core; otherwise it retires as a NOP.
package lanzones_pkg;

  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;

  // ALU funct3
  localparam logic [2:0] F3_ADD  = 3'd0;
  localparam logic [2:0] F3_SLL  = 3'd1;
  localparam logic [2:0] F3_SLT  = 3'd2;
  localparam logic [2:0] F3_SLTU = 3'd3;
  localparam logic [2:0] F3_XOR  = 3'd4;
  localparam logic [2:0] F3_SR   = 3'd5;
  localparam logic [2:0] F3_OR   = 3'd6;
  // branch funct3
  localparam logic [2:0] F3_BEQ  = 3'd0;
  localparam logic [2:0] F3_BNE  = 3'd1;
  localparam logic [2:0] F3_BLT  = 3'd4;
  localparam logic [2:0] F3_BGE  = 3'd5;
  localparam logic [2:0] F3_BLTU = 3'd6;
  localparam logic [2:0] F3_BGEU = 3'd7;
  // load/store funct3
  localparam logic [2:0] F3_LB   = 3'd0;
  localparam logic [2:0] F3_LH   = 3'd1;
  localparam logic [2:0] F3_LBU  = 3'd4;
  localparam logic [2:0] F3_LHU  = 3'd5;
  localparam logic [1:0] SZ_B    = 2'd0;
  localparam logic [1:0] SZ_H    = 2'd1;

  localparam logic [31:0] INSN_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INSN_EBREAK = 32'h0010_0073;

`ifdef LANZONES_ILLEGAL_HALT_EN
  localparam bit ILLEGAL_HALT = 1'b1;
`else
  localparam bit ILLEGAL_HALT = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_EXEC, S_LOAD, S_STORE, S_WB, S_HALT
  } state_e;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
  } alu_op_e;

  // alt is instruction bit 30; SUB only exists for register-register ops,
  // while SRA/SRAI both use bit 30.
  function automatic alu_op_e alu_dec(input logic [2:0] f3, input logic alt,
                                      input logic is_reg);
    case (f3)
      F3_ADD:  alu_dec = (alt && is_reg) ? ALU_SUB : ALU_ADD;
      F3_SLL:  alu_dec = ALU_SLL;
      F3_SLT:  alu_dec = ALU_SLT;
      F3_SLTU: alu_dec = ALU_SLTU;
      F3_XOR:  alu_dec = ALU_XOR;
      F3_SR:   alu_dec = alt ? ALU_SRA : ALU_SRL;
      F3_OR:   alu_dec = ALU_OR;
      default: alu_dec = ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/lanzones_alu.sv
// lanzones_alu: combinational RV32I ALU.
//   a, b     in  32  operands
//   op       in      ALU operation
//   br_f3    in  3   branch funct3 selecting the compare
//   y        out 32  result
//   br_taken out 1   branch condition of a vs b
module lanzones_alu
  import lanzones_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  alu_op_e     op,
  input  logic [2:0]  br_f3,
  output logic [31:0] y,
  output logic        br_taken
);

  logic eq, lt, ltu;

  assign eq  = (a == b);
  assign lt  = ($signed(a) < $signed(b));
  assign ltu = (a < b);

  always_comb begin
    y = a + b;
    case (op)
      ALU_SUB:  y = a - b;
      ALU_SLL:  y = a << b[4:0];
      ALU_SLT:  y = {31'b0, lt};
      ALU_SLTU: y = {31'b0, ltu};
      ALU_XOR:  y = a ^ b;
      ALU_SRL:  y = a >> b[4:0];
      ALU_SRA:  y = $signed(a) >>> b[4:0];
      ALU_OR:   y = a | b;
      ALU_AND:  y = a & b;
      default:  y = a + b;
    endcase
  end

  always_comb begin
    br_taken = 1'b0;
    case (br_f3)
      F3_BEQ:  br_taken = eq;
      F3_BNE:  br_taken = !eq;
      F3_BLT:  br_taken = lt;
      F3_BGE:  br_taken = !lt;
      F3_BLTU: br_taken = ltu;
      F3_BGEU: br_taken = !ltu;
      default: br_taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/lanzones.sv
// lanzones: multicycle RV32I core on a single shared instruction/data port.
//   clk, rstn   clock, synchronous active-low reset
//   LEn         start pulse (IDLE only), begins fetching at RESET_PC
//   RRdy/RAddr  read request and word address (RAddr also addresses writes)
//   RVld/RData  read response
//   RWEn        one-cycle store strobe with RWData/RWStrobe byte lanes
//   Halt        sticky, set after ECALL/EBREAK retires
// Build option LANZONES_ILLEGAL_HALT_EN: unknown opcodes halt instead of NOP.
module lanzones
  import lanzones_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        LEn,
  output logic        RRdy,
  input  logic        RVld,
  input  logic [31:0] RData,
  output logic [31:0] RAddr,
  output logic        RWEn,
  output logic [31:0] RWData,
  output logic [3:0]  RWStrobe,
  output logic        Halt
);

  state_e      state, state_nxt;
  logic [31:0] pc, ir, npc, res, maddr;
  logic        rd_we;
  logic [31:0] rf [32];

  // decode fields
  logic [6:0]  opc;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  f3;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [31:0] rs1_v, rs2_v, pc_p4;

  assign opc   = ir[6:0];
  assign rd    = ir[11:7];
  assign f3    = ir[14:12];
  assign rs1   = ir[19:15];
  assign rs2   = ir[24:20];
  assign imm_i = {{20{ir[31]}}, ir[31:20]};
  assign imm_s = {{20{ir[31]}}, ir[31:25], ir[11:7]};
  assign imm_b = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
  assign imm_u = {ir[31:12], 12'b0};
  assign imm_j = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
  assign rs1_v = (rs1 == 5'd0) ? 32'd0 : rf[rs1];
  assign rs2_v = (rs2 == 5'd0) ? 32'd0 : rf[rs2];
  assign pc_p4 = pc + 32'd4;

  // ALU
  logic [31:0] alu_a, alu_b, alu_y;
  alu_op_e     alu_op;
  logic        br_taken;

  lanzones_alu u_alu (
    .a(alu_a), .b(alu_b), .op(alu_op), .br_f3(f3), .y(alu_y), .br_taken(br_taken)
  );

  // EXEC decode: the ALU defaults to rs1 + imm_i, which doubles as the
  // load address and the JALR target.
  logic [31:0] ex_res, ex_npc;
  logic        ex_we, ex_load, ex_store, ex_halt;

  always_comb begin
    alu_a    = rs1_v;
    alu_b    = imm_i;
    alu_op   = ALU_ADD;
    ex_res   = alu_y;
    ex_npc   = pc_p4;
    ex_we    = 1'b0;
    ex_load  = 1'b0;
    ex_store = 1'b0;
    ex_halt  = 1'b0;
    case (opc)
      OPC_LUI:      begin alu_a = 32'd0; alu_b = imm_u; ex_we = 1'b1; end
      OPC_AUIPC:    begin alu_a = pc;    alu_b = imm_u; ex_we = 1'b1; end
      OPC_JAL:      begin ex_res = pc_p4; ex_npc = pc + imm_j; ex_we = 1'b1; end
      OPC_JALR:     begin ex_res = pc_p4; ex_npc = alu_y & ~32'd1; ex_we = 1'b1; end
      OPC_BRANCH:   begin
        alu_b = rs2_v;
        if (br_taken) ex_npc = pc + imm_b;
      end
      OPC_LOAD:     begin ex_load = 1'b1; ex_we = 1'b1; end
      OPC_STORE:    begin alu_b = imm_s; ex_store = 1'b1; end
      OPC_OP_IMM:   begin alu_op = alu_dec(f3, ir[30], 1'b0); ex_we = 1'b1; end
      OPC_OP:       begin alu_b = rs2_v; alu_op = alu_dec(f3, ir[30], 1'b1); ex_we = 1'b1; end
      OPC_MISC_MEM: ;
      OPC_SYSTEM:   ex_halt = (ir == INSN_ECALL || ir == INSN_EBREAK) ? 1'b1 : ILLEGAL_HALT;
      default:      ex_halt = ILLEGAL_HALT;
    endcase
  end

  // load extract: half select ignores a[0], so misaligned halves read aligned
  logic [31:0] ld_b, ld_h, ld_val;
  assign ld_b = RData >> {maddr[1:0], 3'b000};
  assign ld_h = RData >> {maddr[1], 4'b0000};

  always_comb begin
    case (f3)
      F3_LB:   ld_val = {{24{ld_b[7]}}, ld_b[7:0]};
      F3_LBU:  ld_val = {24'b0, ld_b[7:0]};
      F3_LH:   ld_val = {{16{ld_h[15]}}, ld_h[15:0]};
      F3_LHU:  ld_val = {16'b0, ld_h[15:0]};
      default: ld_val = RData;
    endcase
  end

  // store lanes: data replicated across lanes, strobe picks the target lane
  logic [31:0] st_data;
  logic [3:0]  st_strb;

  always_comb begin
    case (f3[1:0])
      SZ_B:    begin st_strb = 4'b0001 << maddr[1:0];        st_data = {4{rs2_v[7:0]}};  end
      SZ_H:    begin st_strb = 4'b0011 << {maddr[1], 1'b0}; st_data = {2{rs2_v[15:0]}}; end
      default: begin st_strb = 4'b1111;                      st_data = rs2_v;            end
    endcase
  end

  // FSM: state register
  always_ff @(posedge clk) begin
    if (!rstn) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // FSM: next state
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (LEn) state_nxt = S_FETCH;
      S_FETCH: if (RVld) state_nxt = S_EXEC;
      S_EXEC:  begin
        if (ex_halt)       state_nxt = S_HALT;
        else if (ex_load)  state_nxt = S_LOAD;
        else if (ex_store) state_nxt = S_STORE;
        else               state_nxt = S_WB;
      end
      S_LOAD:  if (RVld) state_nxt = S_WB;
      S_STORE: state_nxt = S_FETCH;
      S_WB:    state_nxt = S_FETCH;
      default: state_nxt = S_HALT;
    endcase
  end

  // FSM: outputs
  always_comb begin
    RRdy     = 1'b0;
    RWEn     = 1'b0;
    RAddr    = 32'd0;
    RWData   = 32'd0;
    RWStrobe = 4'd0;
    Halt     = 1'b0;
    case (state)
      S_FETCH: begin RRdy = 1'b1; RAddr = {2'b00, pc[31:2]}; end
      S_LOAD:  begin RRdy = 1'b1; RAddr = {2'b00, maddr[31:2]}; end
      S_STORE: begin
        RWEn     = 1'b1;
        RAddr    = {2'b00, maddr[31:2]};
        RWData   = st_data;
        RWStrobe = st_strb;
      end
      S_HALT:  Halt = 1'b1;
      default: ;
    endcase
  end

  // datapath registers; PC and rd commit in WB (or STORE for stores)
  always_ff @(posedge clk) begin
    if (!rstn) begin
      pc    <= RESET_PC;
      ir    <= 32'd0;
      npc   <= 32'd0;
      res   <= 32'd0;
      maddr <= 32'd0;
      rd_we <= 1'b0;
    end else begin
      case (state)
        S_FETCH: if (RVld) ir <= RData;
        S_EXEC:  begin
          res   <= ex_res;
          npc   <= ex_npc;
          rd_we <= ex_we;
          maddr <= alu_y;
        end
        S_LOAD:  if (RVld) res <= ld_val;
        S_STORE: pc <= npc;
        S_WB:    pc <= npc;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < 32; i++) rf[i] <= 32'd0;
    end else if (state == S_WB && rd_we && rd != 5'd0) begin
      rf[rd] <= res;
    end
  end

endmodule

// File: tb/tb_lanzones.sv
// tb_lanzones: self-checking bench for lanzones. An instruction-level reference
// model runs each program first and queues the stores it expects; a monitor
// compares every DUT store against that queue. Directed programs also check
// final memory words against hand-derived constants.
module tb_lanzones;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        LEn = 1'b0;
  logic        RRdy, RVld, RWEn, Halt;
  logic [31:0] RData, RAddr, RWData;
  logic [3:0]  RWStrobe;

  always #5 clk = ~clk;

  lanzones #(.RESET_PC(32'h0)) dut (
    .clk(clk), .rstn(rstn), .LEn(LEn), .RRdy(RRdy), .RVld(RVld), .RData(RData),
    .RAddr(RAddr), .RWEn(RWEn), .RWData(RWData), .RWStrobe(RWStrobe), .Halt(Halt)
  );

  int checks = 0;
  int passes = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // memory model: registered RData, RVld one cycle after RRdy
  logic [31:0] mem [1024];
  logic [31:0] img [1024];
  logic [31:0] rmem [1024];
  logic        img_load = 1'b0;

  always @(posedge clk) begin
    if (img_load) begin
      for (int i = 0; i < 1024; i++) mem[i] <= img[i];
    end else if (RWEn) begin
      for (int b = 0; b < 4; b++)
        if (RWStrobe[b]) mem[RAddr[9:0]][8*b +: 8] <= RWData[8*b +: 8];
    end
    if (!rstn) RVld <= 1'b0;
    else       RVld <= RRdy && !RVld;
    RData <= mem[RAddr[9:0]];
  end

  // expected store stream
  typedef struct packed {
    logic [31:0] waddr;
    logic [3:0]  strb;
    logic [31:0] data;
  } st_t;
  st_t exp_q[$];
  logic [3:0] last_strb = 4'd0;
  logic       prev_take = 1'b0;

  always @(negedge clk) begin
    if (!rstn) begin
      prev_take = 1'b0;
    end else begin
      if (RWEn) begin
        last_strb = RWStrobe;
        if (exp_q.size() == 0) begin
          checks++;
          $display("FAIL store_unexpected: got store addr %h data %h strobe %b, expected none",
                   RAddr, RWData, RWStrobe);
        end else begin
          st_t e;
          logic [31:0] m;
          e = exp_q.pop_front();
          m = {{8{e.strb[3]}}, {8{e.strb[2]}}, {8{e.strb[1]}}, {8{e.strb[0]}}};
          chk("store_addr", RAddr, e.waddr);
          chk("store_strobe", {28'd0, RWStrobe}, {28'd0, e.strb});
          chk("store_data", RWData & m, e.data & m);
          chk("store_no_read", {31'd0, RRdy}, 32'd0);
        end
      end
      if (prev_take) chk("read_gap", {31'd0, RRdy}, 32'd0);
      prev_take = RRdy && RVld;
      if (Halt) chk("halt_quiet", {30'd0, RRdy, RWEn}, 32'd0);
    end
  end

  // encoders
  function automatic logic [31:0] enc_i(input logic [6:0] op, input logic [4:0] rd,
      input logic [2:0] f3, input logic [4:0] rs1, input logic [11:0] imm);
    return {imm, rs1, f3, rd, op};
  endfunction
  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
      input logic [4:0] rs1, input logic [2:0] f3, input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'h33};
  endfunction
  function automatic logic [31:0] enc_s(input logic [2:0] f3, input logic [4:0] rs1,
      input logic [4:0] rs2, input logic [11:0] imm);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'h23};
  endfunction
  function automatic logic [31:0] enc_b(input logic [2:0] f3, input logic [4:0] rs1,
      input logic [4:0] rs2, input logic [12:0] off);
    return {off[12], off[10:5], rs2, rs1, f3, off[4:1], off[11], 7'h63};
  endfunction
  function automatic logic [31:0] enc_j(input logic [4:0] rd, input logic [20:0] off);
    return {off[20], off[10:1], off[11], off[19:12], rd, 7'h6f};
  endfunction

  // reference model: interprets rmem instruction by instruction
  task automatic ref_run();
    logic [31:0] x [32];
    logic [31:0] pc, ins, a, b, op2, r, nxt, addr, w, immi, imms;
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic        wr, take;
    int          k;
    st_t         s;
    for (int i = 0; i < 32; i++) x[i] = 32'd0;
    pc = 32'd0;
    for (int step = 0; step < 20000; step++) begin
      ins = rmem[pc[11:2]];
      if (ins == 32'h0000_0073 || ins == 32'h0010_0073) return;
      opc  = ins[6:0];
      f3   = ins[14:12];
      a    = x[ins[19:15]];
      b    = x[ins[24:20]];
      immi = {{20{ins[31]}}, ins[31:20]};
      imms = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      nxt  = pc + 32'd4;
      wr   = 1'b0;
      r    = 32'd0;
      case (opc)
        7'h37: begin r = {ins[31:12], 12'd0}; wr = 1'b1; end
        7'h17: begin r = pc + {ins[31:12], 12'd0}; wr = 1'b1; end
        7'h6f: begin
          r = pc + 32'd4; wr = 1'b1;
          nxt = pc + {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
        end
        7'h67: begin r = pc + 32'd4; wr = 1'b1; nxt = (a + immi) & 32'hFFFF_FFFE; end
        7'h63: begin
          case (f3)
            3'd0: take = (a == b);
            3'd1: take = (a != b);
            3'd4: take = ($signed(a) < $signed(b));
            3'd5: take = ($signed(a) >= $signed(b));
            3'd6: take = (a < b);
            3'd7: take = (a >= b);
            default: take = 1'b0;
          endcase
          if (take) nxt = pc + {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
        end
        7'h03: begin
          addr = a + immi;
          w = rmem[addr[11:2]];
          wr = 1'b1;
          case (f3)
            3'd0: begin w = w >> (8 * int'(addr[1:0])); r = {{24{w[7]}}, w[7:0]}; end
            3'd4: begin w = w >> (8 * int'(addr[1:0])); r = {24'd0, w[7:0]}; end
            3'd1: begin w = w >> (addr[1] ? 16 : 0); r = {{16{w[15]}}, w[15:0]}; end
            3'd5: begin w = w >> (addr[1] ? 16 : 0); r = {16'd0, w[15:0]}; end
            default: r = w;
          endcase
        end
        7'h23: begin
          addr = a + imms;
          s.waddr = {2'b00, addr[31:2]};
          case (f3)
            3'd0: begin
              k = int'(addr[1:0]);
              rmem[addr[11:2]][8*k +: 8] = b[7:0];
              s.strb = 4'b0001 << k;
              s.data = {24'd0, b[7:0]} << (8 * k);
            end
            3'd1: begin
              k = addr[1] ? 2 : 0;
              rmem[addr[11:2]][8*k +: 16] = b[15:0];
              s.strb = 4'b0011 << k;
              s.data = {16'd0, b[15:0]} << (8 * k);
            end
            default: begin
              rmem[addr[11:2]] = b;
              s.strb = 4'b1111;
              s.data = b;
            end
          endcase
          exp_q.push_back(s);
        end
        7'h13, 7'h33: begin
          op2 = (opc == 7'h13) ? immi : b;
          wr = 1'b1;
          case (f3)
            3'd0: r = (opc == 7'h33 && ins[30]) ? a - op2 : a + op2;
            3'd1: r = a << op2[4:0];
            3'd2: r = {31'd0, $signed(a) < $signed(op2)};
            3'd3: r = {31'd0, a < op2};
            3'd4: r = a ^ op2;
            3'd5: r = ins[30] ? $signed(a) >>> op2[4:0] : a >> op2[4:0];
            3'd6: r = a | op2;
            default: r = a & op2;
          endcase
        end
        7'h0f: ;
        default: begin
`ifdef LANZONES_ILLEGAL_HALT_EN
          return;
`endif
        end
      endcase
      if (wr && ins[11:7] != 5'd0) x[ins[11:7]] = r;
      pc = nxt;
    end
  endtask

  task automatic clear_img();
    for (int i = 0; i < 1024; i++) img[i] = 32'd0;
  endtask

  task automatic do_reset();
    @(negedge clk) rstn = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
  endtask

  // reset, load image into both memories, build the expected store stream
  task automatic prep();
    do_reset();
    for (int i = 0; i < 1024; i++) rmem[i] = img[i];
    exp_q.delete();
    ref_run();
    @(negedge clk) img_load = 1'b1;
    @(negedge clk) img_load = 1'b0;
  endtask

  task automatic start();
    @(negedge clk) LEn = 1'b1;
    @(negedge clk) LEn = 1'b0;
  endtask

  task automatic run_to_halt(input string name, input int budget);
    int n;
    start();
    n = 0;
    while (!Halt && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_halt"}, {31'd0, Halt}, 32'd1);
    repeat (4) @(negedge clk);
    chk({name, "_pending"}, exp_q.size(), 32'd0);
  endtask

  initial begin
    logic [2:0] f3;
    logic [4:0] rd, r1, r2;
    int         n;

    // 1: idle after reset
    clear_img();
    do_reset();
    repeat (20) @(negedge clk);
    chk("idle_rrdy", {31'd0, RRdy}, 32'd0);
    chk("idle_rwen", {31'd0, RWEn}, 32'd0);
    chk("idle_halt", {31'd0, Halt}, 32'd0);
    chk("idle_raddr", RAddr, 32'd0);

    // 2: addi / sw / ecall
    clear_img();
    img[0] = 32'h0050_0093;
    img[1] = 32'h4010_2023;
    img[2] = 32'h0010_0073;
    prep();
    run_to_halt("t2", 500);
    chk("t2_word", mem[10'h100], 32'd5);

    // 3: add/sub/slt/sltu
    clear_img();
    img[0] = enc_i(7'h13, 5'd1, 3'd0, 5'd0, 12'd7);
    img[1] = enc_i(7'h13, 5'd2, 3'd0, 5'd0, 12'hFFD);
    img[2] = enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd3);
    img[3] = enc_r(7'h20, 5'd2, 5'd1, 3'd0, 5'd4);
    img[4] = enc_r(7'h00, 5'd1, 5'd2, 3'd2, 5'd5);
    img[5] = enc_r(7'h00, 5'd1, 5'd2, 3'd3, 5'd6);
    img[6] = enc_s(3'd2, 5'd0, 5'd3, 12'h400);
    img[7] = enc_s(3'd2, 5'd0, 5'd4, 12'h404);
    img[8] = enc_s(3'd2, 5'd0, 5'd5, 12'h408);
    img[9] = enc_s(3'd2, 5'd0, 5'd6, 12'h40C);
    img[10] = 32'h0000_0073;
    prep();
    run_to_halt("t3", 1000);
    chk("t3_add", mem[10'h100], 32'd4);
    chk("t3_sub", mem[10'h101], 32'd10);
    chk("t3_slt", mem[10'h102], 32'd1);
    chk("t3_sltu", mem[10'h103], 32'd0);

    // 4: byte/half loads with sign/zero extension (lhu at a misaligned address)
    clear_img();
    img[10'h100] = 32'h80FF_7F01;
    img[0] = enc_i(7'h03, 5'd1, 3'd0, 5'd0, 12'h400);
    img[1] = enc_i(7'h03, 5'd2, 3'd4, 5'd0, 12'h401);
    img[2] = enc_i(7'h03, 5'd3, 3'd1, 5'd0, 12'h402);
    img[3] = enc_i(7'h03, 5'd4, 3'd5, 5'd0, 12'h403);
    img[4] = enc_s(3'd2, 5'd0, 5'd1, 12'h500);
    img[5] = enc_s(3'd2, 5'd0, 5'd2, 12'h504);
    img[6] = enc_s(3'd2, 5'd0, 5'd3, 12'h508);
    img[7] = enc_s(3'd2, 5'd0, 5'd4, 12'h50C);
    img[8] = 32'h0010_0073;
    prep();
    run_to_halt("t4", 1000);
    chk("t4_lb", mem[10'h140], 32'h0000_0001);
    chk("t4_lbu", mem[10'h141], 32'h0000_007F);
    chk("t4_lh", mem[10'h142], 32'hFFFF_80FF);
    chk("t4_lhu", mem[10'h143], 32'h0000_80FF);

    // 5: sb into lane 2
    clear_img();
    img[0] = enc_i(7'h13, 5'd1, 3'd0, 5'd0, 12'h0AA);
    img[1] = enc_s(3'd0, 5'd0, 5'd1, 12'h402);
    img[2] = 32'h0000_0073;
    prep();
    run_to_halt("t5", 500);
    chk("t5_strobe", {28'd0, last_strb}, 32'h4);
    chk("t5_word", mem[10'h100], 32'h00AA_0000);

    // 6: bne loop + jal/jalr, with a reset in the middle of the loop
    clear_img();
    img[0] = enc_i(7'h13, 5'd1, 3'd0, 5'd0, 12'd0);
    img[1] = enc_i(7'h13, 5'd2, 3'd0, 5'd0, 12'd10);
    img[2] = enc_i(7'h13, 5'd1, 3'd0, 5'd1, 12'd1);
    img[3] = enc_b(3'd1, 5'd1, 5'd2, 13'h1FFC);
    img[4] = enc_j(5'd5, 21'd16);
    img[5] = enc_s(3'd2, 5'd0, 5'd1, 12'h400);
    img[6] = enc_s(3'd2, 5'd0, 5'd5, 12'h404);
    img[7] = 32'h0000_0073;
    img[8] = enc_i(7'h13, 5'd3, 3'd0, 5'd0, 12'd1);
    img[9] = enc_i(7'h67, 5'd0, 3'd0, 5'd5, 12'd0);
    prep();
    start();
    repeat (40) @(negedge clk);
    chk("t6_midloop_nostore", exp_q.size(), 32'd2);
    chk("t6_midloop_nohalt", {31'd0, Halt}, 32'd0);
    do_reset();
    chk("t6_reset_rrdy", {31'd0, RRdy}, 32'd0);
    run_to_halt("t6", 2000);
    chk("t6_x1", mem[10'h100], 32'd10);
    chk("t6_link", mem[10'h101], 32'd20);

    // 7: unknown opcode
    clear_img();
    img[0] = 32'h0000_000B;
    img[1] = enc_i(7'h13, 5'd1, 3'd0, 5'd0, 12'd9);
    img[2] = enc_s(3'd2, 5'd0, 5'd1, 12'h408);
    img[3] = 32'h0000_0073;
    prep();
    run_to_halt("t7", 500);
`ifdef LANZONES_ILLEGAL_HALT_EN
    chk("t7_word", mem[10'h102], 32'd0);
`else
    chk("t7_word", mem[10'h102], 32'd9);
`endif

    // random programs: forward-only control flow, then dump x1..x7
    for (int t = 0; t < 8; t++) begin
      clear_img();
      for (int k = 0; k < 64; k++) img[10'h100 + k] = $urandom;
      n = 40;
      for (int i = 0; i < n; i++) begin
        rd = 5'($urandom_range(1, 7));
        r1 = 5'($urandom_range(0, 7));
        r2 = 5'($urandom_range(0, 7));
        f3 = 3'($urandom_range(0, 7));
        case ($urandom_range(0, 7))
          0, 1: img[i] = enc_r(((f3 == 3'd0 || f3 == 3'd5) && $urandom_range(0, 1) == 1)
                               ? 7'h20 : 7'h00, r2, r1, f3, rd);
          2: begin
            if (f3 == 3'd1)      img[i] = enc_i(7'h13, rd, f3, r1, {7'h00, 5'($urandom)});
            else if (f3 == 3'd5) img[i] = enc_i(7'h13, rd, f3, r1,
                                   {($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00, 5'($urandom)});
            else                 img[i] = enc_i(7'h13, rd, f3, r1, 12'($urandom));
          end
          3: img[i] = {20'($urandom), rd, ($urandom_range(0, 1) == 1) ? 7'h37 : 7'h17};
          4: img[i] = enc_s(3'($urandom_range(0, 2)), 5'd0, r2,
                            12'h400 + 12'($urandom_range(0, 255)));
          5: begin
            case ($urandom_range(0, 4))
              0: f3 = 3'd0; 1: f3 = 3'd1; 2: f3 = 3'd2; 3: f3 = 3'd4; default: f3 = 3'd5;
            endcase
            img[i] = enc_i(7'h03, rd, f3, 5'd0, 12'h400 + 12'($urandom_range(0, 255)));
          end
          6: begin
            if (f3 == 3'd2 || f3 == 3'd3) f3 = 3'd1;
            img[i] = enc_b(f3, r1, r2, 13'd8);
          end
          default: begin
            if ($urandom_range(0, 1) == 1) img[i] = enc_j(rd, 21'd8);
            else img[i] = enc_i(7'h67, rd, 3'd0, 5'd0,
                                12'((i + 2) * 4 + int'($urandom_range(0, 1))));
          end
        endcase
      end
      for (int k = 1; k < 8; k++)
        img[n + k - 1] = enc_s(3'd2, 5'd0, 5'(k), 12'(12'h600 + 4 * k));
      img[n + 7] = 32'h0000_0073;
      prep();
      run_to_halt("rand", 3000);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
